// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs the decoded RX byte stream into 64-bit words, adds a
// per-packet trailer and buffers the words in an FWFT FIFO for the RX DMA.
module rx_byte_packer #(
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        pkt_header_valid_strobe,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
    input  logic        byte_in_strobe,
    input  logic [7:0]  byte_in,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, TRAILER} state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [15:0]   cnt_q;
    logic [15:0]   len_q;
    logic [7:0]    rate_q;
    logic [63:0]   pack_q;
    logic          fcs_q;
    logic          abort_q;
    logic          ovf_q;
    logic [15:0]   drop_q;
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic [64:0]   mem_q [DEPTH];

    logic          empty;
    logic          full;
    logic          pop;
    logic          space;
    logic          byte_go;
    logic          word_done;
    logic          drop;
    logic          push;
    logic [64:0]   push_data;
    logic [63:0]   pack_d;
    logic [63:0]   trailer;
    logic [2:0]    idx_d;
    logic [64:0]   head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && m_tready;
    // A pop in the same cycle frees the slot the push needs.
    assign space = !full || pop;

    assign byte_go   = (state_q == COLLECT) && byte_in_strobe;
    assign word_done = byte_go && (idx_q == 3'd7);
    assign drop      = word_done && !space;
    assign idx_d     = byte_go ? 3'(idx_q + 3'd1) : idx_q;
    assign pack_d    = pack_q | ({56'd0, byte_in} << {idx_q, 3'b000});

    assign trailer = {fcs_q, abort_q, ovf_q, 13'd0,
                      cnt_q, len_q, 8'd0, rate_q};

    always_comb begin
        push      = 1'b0;
        push_data = 65'd0;
        unique case (state_q)
            COLLECT: begin
                push      = word_done && space;
                push_data = {1'b0, byte_in, pack_q[55:0]};
            end
            FLUSH: begin
                push      = space;
                push_data = {1'b0, pack_q};
            end
            TRAILER: begin
                push      = space;
                push_data = {1'b1, trailer};
            end
            default: begin
                push      = 1'b0;
                push_data = 65'd0;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            rate_q  <= 8'd0;
            pack_q  <= 64'd0;
            fcs_q   <= 1'b0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 16'd0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (pkt_header_valid_strobe) begin
                        state_q <= COLLECT;
                        rate_q  <= pkt_rate;
                        len_q   <= pkt_len;
                        cnt_q   <= 16'd0;
                        idx_q   <= 3'd0;
                        pack_q  <= 64'd0;
                        fcs_q   <= 1'b0;
                        abort_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_go) begin
                        idx_q  <= idx_d;
                        pack_q <= (idx_q == 3'd7) ? 64'd0 : pack_d;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end
                    // The byte of this cycle is packed before the end is handled.
                    if (fcs_out_strobe) begin
                        fcs_q   <= fcs_ok;
                        state_q <= (idx_d != 3'd0) ? FLUSH : TRAILER;
                    end else if (pkt_header_valid_strobe) begin
                        fcs_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= (idx_d != 3'd0) ? FLUSH : TRAILER;
                    end
                end
                FLUSH: begin
                    if (space) begin
                        state_q <= TRAILER;
                    end
                end
                TRAILER: begin
                    if (space) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign head     = empty ? 65'd0 : mem_q[rd_q[AW-1:0]];
    assign m_tvalid = !empty;
    assign m_tdata  = head[63:0];
    assign m_tlast  = head[64];
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Directed bench for rx_byte_packer: table of single packets plus
// backpressure, abort and mid-packet reset sequences.
module tb_rx_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        hdr;
    logic [7:0]  rate;
    logic [15:0] len;
    logic        bstb;
    logic [7:0]  bdat;
    logic        fstb;
    logic        fok;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks;
    int failures;
    logic [64:0] q[$];

    rx_byte_packer #(.FIFO_ADDR_WIDTH(2)) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .pkt_header_valid_strobe(hdr),
        .pkt_rate(rate),
        .pkt_len(len),
        .byte_in_strobe(bstb),
        .byte_in(bdat),
        .fcs_out_strobe(fstb),
        .fcs_ok(fok),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            q.push_back({m_tlast, m_tdata});
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  rate;
        logic [15:0] len;
        int          nb;
        logic        same;
        logic        ok;
        int          nw;
        logic [1:0][63:0] w;
        logic [63:0] tr;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [64:0] entry(input int k);
        if (k < q.size()) return q[k];
        return 65'bx;
    endfunction

    task automatic header(input logic [7:0] r, input logic [15:0] l);
        hdr  = 1'b1;
        rate = r;
        len  = l;
        tick();
        hdr  = 1'b0;
    endtask

    task automatic run_pkt(input logic [7:0] r, input logic [15:0] l,
                           input int n, input logic [7:0] first,
                           input logic same, input logic ok);
        header(r, l);
        for (int i = 0; i < n; i++) begin
            bstb = 1'b1;
            bdat = first + 8'(i);
            if (same && i == n - 1) begin
                fstb = 1'b1;
                fok  = ok;
            end
            tick();
            bstb = 1'b0;
            fstb = 1'b0;
        end
        if (!same || n == 0) begin
            fstb = 1'b1;
            fok  = ok;
            tick();
            fstb = 1'b0;
        end
    endtask

    task automatic wait_words(input string nm, input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        repeat (4) tick();
        chk({nm, " count"}, 65'(q.size()), 65'(n));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        hdr = 0; rate = 0; len = 0;
        bstb = 0; bdat = 0; fstb = 0; fok = 0;
        m_tready = 1'b1;

        vt[0] = '{"T1", 8'h0B, 16'd12, 12, 1'b0, 1'b1, 2,
                  {64'h000000000C0B0A09, 64'h0807060504030201},
                  64'h8000_000C_000C_000B};
        vt[1] = '{"T2", 8'h0D, 16'd16, 16, 1'b0, 1'b0, 2,
                  {64'h100F0E0D0C0B0A09, 64'h0807060504030201},
                  64'h0000_0010_0010_000D};
        vt[2] = '{"T3", 8'h2A, 16'd5, 5, 1'b1, 1'b1, 1,
                  {64'd0, 64'h0000000504030201},
                  64'h8000_0005_0005_002A};
        vt[3] = '{"one", 8'h01, 16'd1, 1, 1'b1, 1'b1, 1,
                  {64'd0, 64'h0000000000000001},
                  64'h8000_0001_0001_0001};
        vt[4] = '{"eight", 8'h07, 16'd8, 8, 1'b1, 1'b1, 1,
                  {64'd0, 64'h0807060504030201},
                  64'h8000_0008_0008_0007};
        vt[5] = '{"empty", 8'hFF, 16'd0, 0, 1'b0, 1'b1, 0,
                  {64'd0, 64'd0},
                  64'h8000_0000_0000_00FF};

        #12;
        chk("rst_tvalid", 65'(m_tvalid), 65'd0);
        chk("rst_tdata", 65'(m_tdata), 65'd0);
        chk("rst_tlast", 65'(m_tlast), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_drop", 65'(drop_cnt), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 6; r++) begin
            q.delete();
            run_pkt(vt[r].rate, vt[r].len, vt[r].nb, 8'h01,
                    vt[r].same, vt[r].ok);
            wait_words(vt[r].name, vt[r].nw + 1);
            for (int k = 0; k < vt[r].nw; k++) begin
                chk({vt[r].name, " word"}, entry(k), {1'b0, vt[r].w[k]});
            end
            chk({vt[r].name, " trailer"}, entry(vt[r].nw),
                {1'b1, vt[r].tr});
            chk({vt[r].name, " idle"}, 65'(busy), 65'd0);
        end

        // Backpressure: 4-deep FIFO, 6 words offered, trailer stalls.
        q.delete();
        m_tready = 1'b0;
        run_pkt(8'h33, 16'd48, 48, 8'h01, 1'b0, 1'b1);
        repeat (5) tick();
        chk("T4 drop_cnt", 65'(drop_cnt), 65'd2);
        chk("T4 busy_stall", 65'(busy), 65'd1);
        chk("T4 head_hold", {m_tlast, m_tdata}, {1'b0, 64'h0807060504030201});
        tick();
        chk("T4 head_stable", {m_tvalid, m_tdata}, {1'b1, 64'h0807060504030201});
        m_tready = 1'b1;
        wait_words("T4", 5);
        chk("T4 w0", entry(0), {1'b0, 64'h0807060504030201});
        chk("T4 w1", entry(1), {1'b0, 64'h100F0E0D0C0B0A09});
        chk("T4 w2", entry(2), {1'b0, 64'h1817161514131211});
        chk("T4 w3", entry(3), {1'b0, 64'h201F1E1D1C1B1A19});
        chk("T4 trailer", entry(4), {1'b1, 64'hA000_0030_0030_0033});
        chk("T4 busy_done", 65'(busy), 65'd0);

        // Second header mid-packet aborts; a header during FLUSH is ignored.
        q.delete();
        header(8'h44, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            bstb = 1'b1;
            bdat = 8'(i + 1);
            tick();
        end
        bstb = 1'b0;
        header(8'h55, 16'd9);
        header(8'h99, 16'd7);
        repeat (3) tick();
        run_pkt(8'h66, 16'd2, 2, 8'hAA, 1'b1, 1'b1);
        wait_words("T5", 4);
        chk("T5 partial", entry(0), {1'b0, 64'h0000000000030201});
        chk("T5 trailer", entry(1), {1'b1, 64'h4000_0003_0020_0044});
        chk("T5 next_word", entry(2), {1'b0, 64'h000000000000ABAA});
        chk("T5 next_trailer", entry(3), {1'b1, 64'h8000_0002_0002_0066});
        chk("T5 drop_kept", 65'(drop_cnt), 65'd2);

        // Asynchronous reset mid-packet with data in the FIFO.
        q.delete();
        m_tready = 1'b0;
        header(8'h77, 16'd20);
        for (int i = 0; i < 10; i++) begin
            bstb = 1'b1;
            bdat = 8'hC0 + 8'(i);
            tick();
        end
        bstb = 1'b0;
        chk("T6 pre_valid", 65'(m_tvalid), 65'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("T6 tvalid", 65'(m_tvalid), 65'd0);
        chk("T6 tdata", 65'(m_tdata), 65'd0);
        chk("T6 tlast", 65'(m_tlast), 65'd0);
        chk("T6 busy", 65'(busy), 65'd0);
        chk("T6 drop", 65'(drop_cnt), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
        tick();
        run_pkt(8'h12, 16'd3, 3, 8'h11, 1'b1, 1'b1);
        wait_words("T6", 2);
        chk("T6 word", entry(0), {1'b0, 64'h0000000000131211});
        chk("T6 trailer", entry(1), {1'b1, 64'h8000_0003_0003_0012});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
